alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Clocked RTL controller sitting between the OP/A/B command channels and a shared 16-bit add/sub ALU datapath.
- Accepts one OP token, then fetches only the operand tokens that opcode requires; the other operand is reused from holding registers.
- Issues a start/done transaction to the datapath.
- Returns the result on channel Y and a status word on channel Z. Both are offered concurrently, and the next OP is accepted only after both are consumed.

Parameters:
W, 16, operand/result/status width
TIMEOUT, 64, max cycles waited for alu_done (used only with ALU_SEQ_TIMEOUT_EN)

Ports:
CLK  in  1  clock; all state changes on rising edge
RESET  in  1  synchronous, active-high reset
op_data  in  2  opcode
op_valid  in  1  OP token offered
op_ready  out  1  OP token accepted when op_valid&op_ready
a_data  in  W  operand A
a_valid  in  1  A offered
a_ready  out  1  A accept
b_data  in  W  operand B
b_valid  in  1  B offered
b_ready  out  1  B accept
alu_a  out  W  datapath operand A (held stable IDLE..RESP)
alu_b  out  W  datapath operand B
alu_sub  out  1  0=add, 1=subtract (a-b)
alu_start  out  1  one-cycle start pulse
alu_done  in  1  datapath result valid
alu_y  in  W  datapath result
alu_c  in  1  datapath carry-out (add) / no-borrow (sub)
y_data  out  W  result token
y_valid  out  1  Y offered
y_ready  in  1  Y accept
z_data  out  W  status token
z_valid  out  1  Z offered
z_ready  in  1  Z accept
busy  out  1  high in every state except IDLE

Behaviour:
- Handshake: a transfer occurs at the rising edge where valid&ready=1. Each ready is a registered output.
- Opcodes:
  - 00: ADD; new A, new B.
  - 01: SUB; new A, new B.
  - 10: ADD; new A, held B.
  - 11: SUB; held A, new B.
- Holding registers hold_a/hold_b: updated on every accepted A/B token.
- FSM states:
  - IDLE: op_ready=1. On OP transfer, latch opcode and go to FETCH.
  - FETCH:
    - a_ready=1 while A is needed and not yet captured; b_ready=1 likewise for B.
    - Opcodes 00/01 accept A and B in either order or in the same cycle.
    - Go to ISSUE on the edge the last needed operand is captured.
  - ISSUE: alu_start=1 for exactly one cycle, then WAIT. alu_a/alu_b/alu_sub are driven from hold_a/hold_b/opcode from ISSUE onward.
  - WAIT:
    - alu_done is sampled only here; alu_done outside WAIT is ignored.
    - On alu_done, register y_data=alu_y and z_data, set y_valid=z_valid=1, go to RESP.
  - RESP:
    - y_valid and z_valid drop independently on their own transfers.
    - When both have been transferred (same or different cycles), return to IDLE.
    - op_ready stays 0 until IDLE.
- Status word z_data:
  - [0] zero: alu_y==0.
  - [1] carry: alu_c.
  - [2] overflow: signed overflow computed from alu_a, alu_b, alu_y and the operation.
  - [3] negative: alu_y[W-1].
  - [W-1:4] = 0.
- Minimum latency, OP accept to Y/Z valid: 4 cycles with 1-cycle datapath and operands already valid.
- Reset:
  - Any cycle, including mid-operation: state=IDLE.
  - All valid/ready/start outputs 0 except op_ready=1 in the cycle after reset deasserts.
  - hold_a=hold_b=0; y_data=z_data=0; busy=0.
  - A pending Y/Z token is discarded.
- Ops 10/11 after reset use 0 for the held operand.
- Opcode is 2 bits, so no illegal values.
- Arithmetic is modulo 2^W.

Optional Feature:
Macro ALU_SEQ_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - If alu_done has not arrived after TIMEOUT cycles, go to RESP with y_data=0, z_data[W-1]=1 and other status bits 0.
  - A late alu_done is ignored.
- Undefined: WAIT holds indefinitely; z_data[W-1] is always 0.

Test Plan:
1. Op 00, A=5, B=3, 1-cycle datapath:
   - alu_sub=0, one alu_start pulse.
   - Y=8, Z=0x0000.
   - op_ready returns high after both are consumed.
2. Op 01, A=3, B=5 → Y=0xFFFE, Z=0x0008 (negative, borrow). Then op 10, A=7, no B token → uses held B=5 → Y=12, and b_ready stays 0 throughout.
3. Op 00 with B offered 3 cycles before A, then 0x7FFF+0x0001 → Y=0x8000, Z=0x000C (overflow, negative). Also verify A/B captured out of order.
4. Back-pressure on Y/Z:
   - z_ready high immediately, y_ready delayed 5 cycles → z_valid drops after 1 cycle, y_valid held for 5.
   - The next OP is not accepted until Y transfers.
5. RESET pulsed in WAIT → all outputs reset. Then op 11, B=2 → Y=0xFFFE (held A=0).
6. ALU_SEQ_TIMEOUT_EN with TIMEOUT=8 and alu_done never asserted → after 8 WAIT cycles Y=0, Z=0x8000; a late alu_done is ignored.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// OP/A/B command sequencer for a shared add/sub datapath; returns result on Y and status on Z.
// Optional WAIT-state watchdog enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_op_sequencer #(
    parameter int unsigned W       = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [1:0]   op_data,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [W-1:0] a_data,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [W-1:0] b_data,
    input  logic         b_valid,
    output logic         b_ready,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_sub,
    output logic         alu_start,
    input  logic         alu_done,
    input  logic [W-1:0] alu_y,
    input  logic         alu_c,
    output logic [W-1:0] y_data,
    output logic         y_valid,
    input  logic         y_ready,
    output logic [W-1:0] z_data,
    output logic         z_valid,
    input  logic         z_ready,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   op_q, op_d;
    logic [W-1:0] hold_a_q, hold_a_d;
    logic [W-1:0] hold_b_q, hold_b_d;
    logic         got_a_q, got_a_d;
    logic         got_b_q, got_b_d;
    logic         op_ready_q, op_ready_d;
    logic         a_ready_q, a_ready_d;
    logic         b_ready_q, b_ready_d;
    logic         alu_start_q, alu_start_d;
    logic         y_valid_q, y_valid_d;
    logic         z_valid_q, z_valid_d;
    logic [W-1:0] y_data_q, y_data_d;
    logic [W-1:0] z_data_q, z_data_d;
    logic [W-1:0] status;
    logic         ovf;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Opcode 11 reuses held A, opcode 10 reuses held B.
    function automatic logic need_a(input logic [1:0] op);
        return op != 2'b11;
    endfunction

    function automatic logic need_b(input logic [1:0] op);
        return op != 2'b10;
    endfunction

    wire op_fire = op_valid & op_ready_q;
    wire a_fire  = a_valid & a_ready_q;
    wire b_fire  = b_valid & b_ready_q;
    wire y_fire  = y_valid_q & y_ready;
    wire z_fire  = z_valid_q & z_ready;

    always_comb begin
        ovf = '0;
        if (op_q[0])
            ovf = (hold_a_q[W-1] != hold_b_q[W-1]) && (alu_y[W-1] != hold_a_q[W-1]);
        else
            ovf = (hold_a_q[W-1] == hold_b_q[W-1]) && (alu_y[W-1] != hold_a_q[W-1]);
        status    = '0;
        status[0] = (alu_y == '0);
        status[1] = alu_c;
        status[2] = ovf;
        status[3] = alu_y[W-1];
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        hold_a_d  = hold_a_q;
        hold_b_d  = hold_b_q;
        got_a_d   = got_a_q;
        got_b_d   = got_b_q;
        y_valid_d = y_valid_q;
        z_valid_d = z_valid_q;
        y_data_d  = y_data_q;
        z_data_d  = z_data_q;
`ifdef ALU_SEQ_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif

        if (a_fire) begin
            hold_a_d = a_data;
            got_a_d  = 1'b1;
        end
        if (b_fire) begin
            hold_b_d = b_data;
            got_b_d  = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (op_fire) begin
                    op_d    = op_data;
                    got_a_d = 1'b0;
                    got_b_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if ((got_a_d || !need_a(op_q)) && (got_b_d || !need_b(op_q)))
                    state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (alu_done) begin
                    y_data_d  = alu_y;
                    z_data_d  = status;
                    y_valid_d = 1'b1;
                    z_valid_d = 1'b1;
                    state_d   = S_RESP;
`ifdef ALU_SEQ_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    y_data_d       = '0;
                    z_data_d       = '0;
                    z_data_d[W-1]  = 1'b1;
                    y_valid_d      = 1'b1;
                    z_valid_d      = 1'b1;
                    state_d        = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            S_RESP: begin
                if (y_fire) y_valid_d = 1'b0;
                if (z_fire) z_valid_d = 1'b0;
                if (!y_valid_d && !z_valid_d)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Readies are registered, so they are derived from the next state.
        op_ready_d  = (state_d == S_IDLE);
        a_ready_d   = (state_d == S_FETCH) && need_a(op_d) && !got_a_d;
        b_ready_d   = (state_d == S_FETCH) && need_b(op_d) && !got_b_d;
        alu_start_d = (state_d == S_ISSUE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            hold_a_q    <= '0;
            hold_b_q    <= '0;
            got_a_q     <= 1'b0;
            got_b_q     <= 1'b0;
            op_ready_q  <= 1'b0;
            a_ready_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            alu_start_q <= 1'b0;
            y_valid_q   <= 1'b0;
            z_valid_q   <= 1'b0;
            y_data_q    <= '0;
            z_data_q    <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            hold_a_q    <= hold_a_d;
            hold_b_q    <= hold_b_d;
            got_a_q     <= got_a_d;
            got_b_q     <= got_b_d;
            op_ready_q  <= op_ready_d;
            a_ready_q   <= a_ready_d;
            b_ready_q   <= b_ready_d;
            alu_start_q <= alu_start_d;
            y_valid_q   <= y_valid_d;
            z_valid_q   <= z_valid_d;
            y_data_q    <= y_data_d;
            z_data_q    <= z_data_d;
`ifdef ALU_SEQ_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign op_ready  = op_ready_q;
    assign a_ready   = a_ready_q;
    assign b_ready   = b_ready_q;
    assign alu_a     = hold_a_q;
    assign alu_b     = hold_b_q;
    assign alu_sub   = op_q[0];
    assign alu_start = alu_start_q;
    assign y_data    = y_data_q;
    assign y_valid   = y_valid_q;
    assign z_data    = z_data_q;
    assign z_valid   = z_valid_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a 1-cycle add/sub datapath model.
// Covers the ALU_SEQ_TIMEOUT_EN watchdog (TIMEOUT=8) when that macro is defined.
module tb_alu_op_sequencer;
    localparam int unsigned W = 16;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [1:0]   op_data;
    logic         op_valid, op_ready;
    logic [W-1:0] a_data, b_data;
    logic         a_valid, a_ready, b_valid, b_ready;
    logic [W-1:0] alu_a, alu_b, alu_y;
    logic         alu_sub, alu_start, alu_done, alu_c;
    logic [W-1:0] y_data, z_data;
    logic         y_valid, y_ready, z_valid, z_ready, busy;

    int unsigned n_checks = 0, n_fail = 0;
    int unsigned n_start = 0, n_a_rdy = 0, n_b_rdy = 0;
    logic         alu_auto = 1'b1, force_done = 1'b0, prev_start;
    logic [W-1:0] man_y = '0;
    logic         man_c = 1'b0;
    int unsigned  snap;

    always #5 CLK = ~CLK;

    alu_op_sequencer #(.W(W), .TIMEOUT(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .op_data(op_data), .op_valid(op_valid), .op_ready(op_ready),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub), .alu_start(alu_start),
        .alu_done(alu_done), .alu_y(alu_y), .alu_c(alu_c),
        .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
        .z_data(z_data), .z_valid(z_valid), .z_ready(z_ready),
        .busy(busy)
    );

    always @(negedge CLK) begin
        if (alu_start) n_start++;
        if (a_ready) n_a_rdy++;
        if (b_ready) n_b_rdy++;
    end

    // Datapath: result and done appear the cycle after the start pulse.
    initial begin
        alu_done = 1'b0; alu_y = '0; alu_c = 1'b0; prev_start = 1'b0;
        forever begin
            @(posedge CLK); #2;
            alu_done = prev_start | force_done;
            if (prev_start)
                {alu_c, alu_y} = alu_sub ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1)
                                         : ({1'b0, alu_a} + {1'b0, alu_b});
            else if (force_done)
                {alu_c, alu_y} = {man_c, man_y};
            prev_start = alu_start & alu_auto;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic wait_resp(input string tag);
        for (int i = 0; i < 50 && !y_valid; i++) tick();
        check(tag, y_valid, 1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic av,
                         input logic [W-1:0] b, input logic bv, input string tag);
        op_data = op; op_valid = 1'b1;
        a_data = a; a_valid = av; b_data = b; b_valid = bv;
        tick();
        op_valid = 1'b0;
        wait_resp(tag);
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic consume();
        y_ready = 1'b1; z_ready = 1'b1;
        tick();
        y_ready = 1'b0; z_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit expected end of test");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1; op_data = '0; op_valid = 1'b0;
        a_data = '0; a_valid = 1'b0; b_data = '0; b_valid = 1'b0;
        y_ready = 1'b0; z_ready = 1'b0;
        tick(); tick();
        check("rst_op_ready", op_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_y_valid", y_valid, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_start", alu_start, 0);
        RESET = 1'b0;
        tick();
        check("post_rst_op_ready", op_ready, 1);

        // 1: op 00, 5+3, cycle-by-cycle latency
        snap = n_start;
        op_data = 2'b00; op_valid = 1'b1;
        a_data = 16'd5; a_valid = 1'b1; b_data = 16'd3; b_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_op_ready", op_ready, 0);
        check("t1_a_ready", a_ready, 1);
        check("t1_b_ready", b_ready, 1);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check("t1_start", alu_start, 1);
        check("t1_sub", alu_sub, 0);
        check("t1_alu_a", alu_a, 16'd5);
        check("t1_alu_b", alu_b, 16'd3);
        tick();
        check("t1_start_low", alu_start, 0);
        check("t1_y_early", y_valid, 0);
        tick();
        check("t1_y_valid", y_valid, 1);
        check("t1_z_valid", z_valid, 1);
        check("t1_y", y_data, 16'd8);
        check("t1_z", z_data, 16'h0000);
        check("t1_op_ready_resp", op_ready, 0);
        check("t1_one_start", n_start - snap, 1);
        consume();
        check("t1_y_gone", y_valid, 0);
        check("t1_z_gone", z_valid, 0);
        check("t1_op_ready_back", op_ready, 1);
        check("t1_idle", busy, 0);

        // 2: op 01 3-5, then op 10 with held B
        issue(2'b01, 16'd3, 1'b1, 16'd5, 1'b1, "t2a_resp");
        check("t2a_sub", alu_sub, 1);
        check("t2a_y", y_data, 16'hFFFE);
        check("t2a_z", z_data, 16'h0008);
        consume();
        snap = n_b_rdy;
        issue(2'b10, 16'd7, 1'b1, 16'hDEAD, 1'b0, "t2b_resp");
        check("t2b_alu_b_held", alu_b, 16'd5);
        check("t2b_y", y_data, 16'd12);
        check("t2b_z", z_data, 16'h0000);
        check("t2b_no_b_ready", n_b_rdy - snap, 0);
        consume();

        // 3: B before A, stray done in FETCH ignored, signed overflow
        op_data = 2'b00; op_valid = 1'b1; b_data = 16'h0001; b_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        b_valid = 1'b0;
        check("t3_b_taken", b_ready, 0);
        check("t3_a_wait", a_ready, 1);
        man_y = 16'h5A5A; force_done = 1'b1;
        tick();
        force_done = 1'b0;
        check("t3_alu_b", alu_b, 16'h0001);
        tick();
        check("t3_done_ignored", y_valid, 0);
        check("t3_no_start", alu_start, 0);
        a_data = 16'h7FFF; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        check("t3_start", alu_start, 1);
        check("t3_alu_a", alu_a, 16'h7FFF);
        wait_resp("t3_resp");
        check("t3_y", y_data, 16'h8000);
        check("t3_z", z_data, 16'h000C);
        consume();

        // 4: Z consumed at once, Y held back; next OP waits for Y
        issue(2'b00, 16'd2, 1'b1, 16'd2, 1'b1, "t4_resp");
        check("t4_y", y_data, 16'd4);
        op_data = 2'b01; op_valid = 1'b1;
        z_ready = 1'b1;
        tick();
        z_ready = 1'b0;
        check("t4_z_drop", z_valid, 0);
        check("t4_y_hold", y_valid, 1);
        check("t4_op_blocked", op_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_y_hold_loop", y_valid, 1);
            check("t4_busy_loop", busy, 1);
        end
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        check("t4_y_drop", y_valid, 0);
        check("t4_op_ready", op_ready, 1);
        check("t4_not_accepted", busy, 0);
        op_valid = 1'b0;
        tick();
        check("t4_still_idle", busy, 0);

        // 5: reset in WAIT, then op 11 with held A cleared to 0
        alu_auto = 1'b0;
        op_data = 2'b00; op_valid = 1'b1;
        a_data = 16'd9; a_valid = 1'b1; b_data = 16'd9; b_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        tick(); tick(); tick();
        check("t5_wait_busy", busy, 1);
        check("t5_wait_no_y", y_valid, 0);
        RESET = 1'b1;
        tick();
        check("t5_rst_busy", busy, 0);
        check("t5_rst_op_ready", op_ready, 0);
        check("t5_rst_y_valid", y_valid, 0);
        check("t5_rst_alu_a", alu_a, 16'd0);
        check("t5_rst_alu_b", alu_b, 16'd0);
        check("t5_rst_y_data", y_data, 16'd0);
        RESET = 1'b0; alu_auto = 1'b1;
        tick();
        check("t5_op_ready", op_ready, 1);
        snap = n_a_rdy;
        issue(2'b11, 16'h5555, 1'b0, 16'd2, 1'b1, "t5_resp");
        check("t5_alu_a_held", alu_a, 16'd0);
        check("t5_y", y_data, 16'hFFFE);
        check("t5_z", z_data, 16'h0008);
        check("t5_no_a_ready", n_a_rdy - snap, 0);
        consume();

        // 6: datapath never answers
        alu_auto = 1'b0;
        op_data = 2'b00; op_valid = 1'b1;
        a_data = 16'd1; a_valid = 1'b1; b_data = 16'd1; b_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
`ifdef ALU_SEQ_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            check("t6_no_y_yet", y_valid, 0);
        end
        tick();
        check("t6_timeout_y_valid", y_valid, 1);
        check("t6_timeout_y", y_data, 16'h0000);
        check("t6_timeout_z", z_data, 16'h8000);
        man_y = 16'h1234; man_c = 1'b1; force_done = 1'b1;
        tick();
        force_done = 1'b0;
        check("t6_late_y", y_data, 16'h0000);
        check("t6_late_z", z_data, 16'h8000);
        consume();
        check("t6_idle", busy, 0);
`else
        for (int i = 0; i < 20; i++) tick();
        check("t6_wait_holds", y_valid, 0);
        check("t6_wait_busy", busy, 1);
        man_y = 16'h1234; man_c = 1'b1; force_done = 1'b1;
        tick();
        force_done = 1'b0;
        check("t6_y_valid", y_valid, 1);
        check("t6_y", y_data, 16'h1234);
        check("t6_z", z_data, 16'h0002);
        consume();
        check("t6_idle", busy, 0);
`endif
        alu_auto = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
